z80_irq_ctrl: RTL and testbench
===============================

// Module: z80_irq_ctrl
// PURPOSE
//  Parametrised IM2 interrupt controller for Z80 host boards. Replaces the fixed 8'h80
//  vector on IORQ reads and the raw KEY-to-nINT wiring.
//  Collects up to 8 request sources, each edge- or level-triggered, with mask and pending.
//  Drives nINT and supplies the vector of the highest-priority source in the INTA cycle.
//  Sits next to uart_io on the host bus; clocked by the fast board clock (pll_clk).
// PARAMETERS
//  NUM_CH        4      number of request channels, 1..8; channel 0 = highest priority
//  EDGE_MODE     8'hFF  per-channel trigger mode: 1 = rising-edge, 0 = level-high
//  VECTOR_BASE   8'h80  vector for channel 0
//  VECTOR_STRIDE 2      vector increment per channel
//  SPUR_VEC      8'hFF  vector driven on INTA when nothing is eligible
//  IO_PORT       8'h03  A[15:8] of the register block; two ports: IO_PORT, IO_PORT+1
// PORTS
//  CLK      in   1        board clock, >= 4x CPU clock
//  nRESET   in   1        asynchronous active-low reset
//  irq_in   in   NUM_CH   request sources, asynchronous to CLK, active high
//  nM1      in   1        CPU M1 strobe
//  nIORQ    in   1        CPU IORQ strobe
//  nRD      in   1        CPU RD strobe
//  nWR      in   1        CPU WR strobe
//  A        in   8        CPU address A[15:8]
//  D_in     in   8        CPU data bus, write direction
//  D_out    out  8        data returned to the CPU: vector or register value
//  D_oe     out  1        host must drive D from D_out while this is 1
//  nINT     out  1        maskable interrupt request to the CPU, active low
// BEHAVIOUR
//  Reset (async, nRESET=0): pending=0, mask=0 (all disabled), state=IDLE, nINT=1,
//   D_oe=0, frozen vector=SPUR_VEC, synchroniser flops=0.
//  Input sync: irq_in and {nM1,nIORQ,nRD,nWR} each pass a 2-FF synchroniser.
//   Latency from irq_in to pending is 3 CLK.
//  Edge channel: pending[i] is set on a synchronised 0->1 edge.
//   It clears only on INTA completion or on a write-1-to-clear.
//  Level channel: pending[i] equals the synchronised level. Clear requests are ignored.
//  Set beats clear: a set and a clear of the same bit in the same CLK leave it set.
//  eligible = pending & mask. nINT = !(|eligible) while IDLE; nINT=1 in ACK state.
//  Winner = lowest-index eligible bit.
//   vec = VECTOR_BASE + idx*VECTOR_STRIDE, truncated to 8 bits (wraps mod 256).
//  FSM IDLE:
//   - Registers vec/idx every CLK from the current winner (SPUR_VEC if none).
//   - Synced nM1=0 and nIORQ=0 -> ACK. vec/idx freeze and nINT deasserts.
//  FSM ACK:
//   - Synced nIORQ=1 -> IDLE.
//   - Same CLK: pending[idx] clears if it was a real winner and the channel is edge mode.
//   - A spurious ack clears nothing.
//  D_oe and D_out are combinational from the raw (unsynchronised) strobes:
//   - INTA (nM1=0 & nIORQ=0): D_oe=1, D_out=frozen vec. During the ack, D_out
//     follows the registered vector until the FSM freezes it (2 CLK after the strobes).
//     The CLK>=4x CPU-clock ratio keeps the frozen value stable when the CPU samples D.
//   - IO read (nM1=1, nIORQ=0, nRD=0) at A==IO_PORT: D_oe=1, D_out=pending (zero-extended).
//   - IO read at A==IO_PORT+1: D_oe=1, D_out=mask.
//   - Otherwise D_oe=0 and D_out=0.
//  IO write (nM1=1, nIORQ=0, nWR=0):
//   - Actions fire once, on the synced falling edge of nWR.
//   - A==IO_PORT+1: mask <= D_in[NUM_CH-1:0].
//   - A==IO_PORT: write-1-to-clear of pending bits.
//  Mask changes never alter pending. The vector is frozen at ack start, so a mask write
//   during ACK does not change the vector being driven.
//  Bits at or above NUM_CH read as 0 and writes to them are ignored.
//  Reset mid-ACK returns to IDLE with nothing pending.
//   The in-flight INTA then reads SPUR_VEC (D_oe still follows the raw strobes).
// TESTING
//  1. Reset, write mask 8'h0F to port IO_PORT+1, pulse irq_in[2]
//     -> nINT=0 within 4 CLK; INTA returns 8'h84; nINT=1 after nIORQ rises; pending=0.
//  2. Raise irq_in[3] and irq_in[1] in the same CLK
//     -> first INTA returns 8'h82, second returns 8'h86, then nINT=1.
//  3. Level channel (EDGE_MODE=8'hFE), irq_in[0] held high
//     -> INTA returns 8'h80 and nINT=0 again after ACK; drop irq_in[0] -> nINT=1.
//  4. Pending 8'h02, write 8'h00 to mask before the INTA
//     -> nINT=1; a forced INTA returns 8'hFF and pending stays 8'h02.
//  5. New edge on ch1 in the same CLK the ACK clears ch1 -> pending[1] remains 1.
//  6. Set VECTOR_BASE=8'hFC, VECTOR_STRIDE=2, trigger ch3 -> vector 8'h02 (wrap).
//     Assert nRESET=0 during an INTA -> nINT=1, pending=0, mask=0.

Source files
------------

// File: rtl/z80_irq_ctrl.sv
// IM2 interrupt controller: up to 8 edge/level sources, mask, pending, vectored INTA on the Z80 bus.
// Latency irq_in->pending 3 CLK; no backpressure, CPU strobes are sampled through 2-FF synchronisers.
module z80_irq_ctrl #(
    parameter int         NUM_CH        = 4,
    parameter logic [7:0] EDGE_MODE     = 8'hFF,
    parameter logic [7:0] VECTOR_BASE   = 8'h80,
    parameter int         VECTOR_STRIDE = 2,
    parameter logic [7:0] SPUR_VEC      = 8'hFF,
    parameter logic [7:0] IO_PORT       = 8'h03
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              nM1,
    input  logic              nIORQ,
    input  logic              nRD,
    input  logic              nWR,
    input  logic [7:0]        A,
    input  logic [7:0]        D_in,
    output logic [7:0]        D_out,
    output logic              D_oe,
    output logic              nINT
);

    localparam logic [NUM_CH-1:0] EDGE_CH   = EDGE_MODE[NUM_CH-1:0];
    localparam logic [7:0]        PORT_MASK = IO_PORT + 8'd1;
    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_ACK    = 1'b1;

    logic [NUM_CH-1:0] irq_s1, irq_s2, irq_prev;
    logic [3:0]        bus_s1, bus_s2;
    logic              nwr_prev;
    logic              m1_s, iorq_s, rd_s, wr_s;
    logic              wr_fire, mask_wr, w1c_wr, inta_s, ack_done;
    logic [NUM_CH-1:0] pending, pending_nxt, mask, eligible;
    logic [NUM_CH-1:0] win_oh, frz_oh, set_vec, clr_vec;
    logic [7:0]        win_vec, frz_vec;
    logic [0:0]        state;
    logic              unused_din;

    assign unused_din = ^D_in;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            irq_s1   <= '0;
            irq_s2   <= '0;
            irq_prev <= '0;
            bus_s1   <= '0;
            bus_s2   <= '0;
            nwr_prev <= 1'b0;
        end else begin
            irq_s1   <= irq_in;
            irq_s2   <= irq_s1;
            irq_prev <= irq_s2;
            bus_s1   <= {nM1, nIORQ, nRD, nWR};
            bus_s2   <= bus_s1;
            nwr_prev <= wr_s;
        end
    end

    assign {m1_s, iorq_s, rd_s, wr_s} = bus_s2;

    // Register writes fire once per CPU write cycle, on the synced falling edge of nWR.
    assign wr_fire  = nwr_prev & ~wr_s & m1_s & ~iorq_s & rd_s;
    assign mask_wr  = wr_fire && (A == PORT_MASK);
    assign w1c_wr   = wr_fire && (A == IO_PORT);
    assign inta_s   = ~m1_s & ~iorq_s;
    assign ack_done = (state == ST_ACK) && iorq_s;

    always_comb begin
        eligible = pending & mask;
        win_oh   = '0;
        win_vec  = SPUR_VEC;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_vec   = 8'(VECTOR_BASE + i * VECTOR_STRIDE);
            end
        end
    end

    // Set beats clear; level channels just track the synchronised input.
    always_comb begin
        set_vec = irq_s2 & ~irq_prev;
        clr_vec = '0;
        if (w1c_wr)
            clr_vec = D_in[NUM_CH-1:0];
        if (ack_done)
            clr_vec = clr_vec | frz_oh;
        pending_nxt = (EDGE_CH & ((pending & ~clr_vec) | set_vec)) | (~EDGE_CH & irq_s2);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= pending_nxt;
            if (mask_wr)
                mask <= D_in[NUM_CH-1:0];
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= ST_IDLE;
            frz_vec <= SPUR_VEC;
            frz_oh  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    frz_vec <= win_vec;
                    frz_oh  <= win_oh;
                    if (inta_s)
                        state <= ST_ACK;
                end
                default: begin
                    if (iorq_s)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    assign nINT = (state == ST_ACK) | ~(|eligible);

    // Bus drive decodes the raw strobes so D is valid within the CPU cycle itself.
    always_comb begin
        D_oe  = 1'b0;
        D_out = 8'h00;
        if (!nM1 && !nIORQ) begin
            D_oe  = 1'b1;
            D_out = frz_vec;
        end else if (nM1 && !nIORQ && !nRD) begin
            if (A == IO_PORT) begin
                D_oe  = 1'b1;
                D_out = 8'(pending);
            end else if (A == PORT_MASK) begin
                D_oe  = 1'b1;
                D_out = 8'(mask);
            end
        end
    end

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Directed bench for z80_irq_ctrl: one instance with ch0 level-triggered, one with a wrapping vector base.
module tb_z80_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_a, irq_w;
    logic       nm1, niorq, nrd, nwr;
    logic [7:0] addr, d_in;
    logic [7:0] d_out_a, d_out_w;
    logic       d_oe_a, d_oe_w, nint_a, nint_w;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_a, rd_w;

    z80_irq_ctrl #(
        .NUM_CH(4), .EDGE_MODE(8'hFE), .VECTOR_BASE(8'h80),
        .VECTOR_STRIDE(2), .SPUR_VEC(8'hFF), .IO_PORT(8'h03)
    ) u_dut (
        .CLK(clk), .nRESET(rst_n), .irq_in(irq_a), .nM1(nm1), .nIORQ(niorq),
        .nRD(nrd), .nWR(nwr), .A(addr), .D_in(d_in),
        .D_out(d_out_a), .D_oe(d_oe_a), .nINT(nint_a)
    );

    z80_irq_ctrl #(
        .NUM_CH(4), .EDGE_MODE(8'hFF), .VECTOR_BASE(8'hFC),
        .VECTOR_STRIDE(2), .SPUR_VEC(8'hFF), .IO_PORT(8'h03)
    ) u_wrap (
        .CLK(clk), .nRESET(rst_n), .irq_in(irq_w), .nM1(nm1), .nIORQ(niorq),
        .nRD(nrd), .nWR(nwr), .A(addr), .D_in(d_in),
        .D_out(d_out_w), .D_oe(d_oe_w), .nINT(nint_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk(tag, obs, exp);
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; d_in = d; nm1 = 1'b1; niorq = 1'b0; nwr = 1'b0;
        tick(4);
        nwr = 1'b1; niorq = 1'b1;
        tick(3);
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] va, output logic [7:0] vw);
        addr = a; nm1 = 1'b1; niorq = 1'b0; nrd = 1'b0;
        #1;
        va = d_out_a; vw = d_out_w;
        nrd = 1'b1; niorq = 1'b1;
        tick(2);
    endtask

    task automatic inta_begin;
        nm1 = 1'b0; niorq = 1'b0;
        tick(4);
    endtask

    task automatic inta_end;
        nm1 = 1'b1; niorq = 1'b1;
        tick(4);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; irq_a = '0; irq_w = '0;
        nm1 = 1'b1; niorq = 1'b1; nrd = 1'b1; nwr = 1'b1;
        addr = 8'h00; d_in = 8'h00;
        tick(2);
        chk("rst_nint", {7'd0, nint_a}, 8'h01);
        chk("rst_doe", {7'd0, d_oe_a}, 8'h00);
        chk("rst_dout", d_out_a, 8'h00);
        rst_n = 1'b1;
        tick(6);
        io_read(8'h03, rd_a, rd_w);
        chk("rst_pending", rd_a, 8'h00);
        io_read(8'h04, rd_a, rd_w);
        chk("rst_mask", rd_a, 8'h00);

        // 1: single edge source on ch2
        io_write(8'h04, 8'h0F);
        io_read(8'h04, rd_a, rd_w);
        chk("mask_rb", rd_a, 8'h0F);
        irq_a = 4'b0100;
        exp_q.push_back(8'h84);
        c = 0;
        while (c < 8 && nint_a) begin
            tick(1);
            c++;
        end
        chk("irq_lat", 8'(c), 8'd3);
        irq_a = '0;
        inta_begin();
        sb_chk("t1_vec", d_out_a);
        chk("t1_doe", {7'd0, d_oe_a}, 8'h01);
        chk("t1_nint_ack", {7'd0, nint_a}, 8'h01);
        inta_end();
        chk("t1_nint_after", {7'd0, nint_a}, 8'h01);
        io_read(8'h03, rd_a, rd_w);
        chk("t1_pending", rd_a, 8'h00);

        // 2: two simultaneous sources, priority order
        irq_a = 4'b1010;
        exp_q.push_back(8'h82);
        exp_q.push_back(8'h86);
        tick(4);
        irq_a = '0;
        tick(1);
        inta_begin();
        sb_chk("t2_vec1", d_out_a);
        inta_end();
        chk("t2_nint_mid", {7'd0, nint_a}, 8'h00);
        inta_begin();
        sb_chk("t2_vec2", d_out_a);
        inta_end();
        chk("t2_nint_end", {7'd0, nint_a}, 8'h01);

        // 3: level channel 0 survives the ack
        irq_a = 4'b0001;
        exp_q.push_back(8'h80);
        tick(4);
        inta_begin();
        sb_chk("t3_vec", d_out_a);
        inta_end();
        chk("t3_nint_held", {7'd0, nint_a}, 8'h00);
        io_read(8'h03, rd_a, rd_w);
        chk("t3_pending", rd_a, 8'h01);
        irq_a = '0;
        tick(4);
        chk("t3_nint_drop", {7'd0, nint_a}, 8'h01);

        // 4: masked pending gives spurious vector and is left untouched
        irq_a = 4'b0010;
        tick(1);
        irq_a = '0;
        tick(4);
        io_read(8'h03, rd_a, rd_w);
        chk("t4_pending_pre", rd_a, 8'h02);
        io_write(8'h04, 8'h00);
        chk("t4_nint_masked", {7'd0, nint_a}, 8'h01);
        exp_q.push_back(8'hFF);
        inta_begin();
        sb_chk("t4_spur_vec", d_out_a);
        inta_end();
        io_read(8'h03, rd_a, rd_w);
        chk("t4_pending_post", rd_a, 8'h02);
        io_write(8'h03, 8'h02);
        io_read(8'h03, rd_a, rd_w);
        chk("t4_w1c", rd_a, 8'h00);
        io_write(8'h04, 8'h0F);

        // 5: new edge lands in the same CLK as the ack clear
        irq_a = 4'b0010;
        tick(1);
        irq_a = '0;
        tick(4);
        exp_q.push_back(8'h82);
        inta_begin();
        sb_chk("t5_vec1", d_out_a);
        irq_a = 4'b0010;
        exp_q.push_back(8'h82);
        inta_end();
        irq_a = '0;
        io_read(8'h03, rd_a, rd_w);
        chk("t5_pending_kept", rd_a, 8'h02);
        chk("t5_nint", {7'd0, nint_a}, 8'h00);
        inta_begin();
        sb_chk("t5_vec2", d_out_a);
        inta_end();
        io_read(8'h03, rd_a, rd_w);
        chk("t5_pending_clr", rd_a, 8'h00);

        // 6: vector wrap, then reset during an INTA
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("t6_rst_nint", {7'd0, nint_w}, 8'h01);
        io_write(8'h04, 8'h0F);
        irq_w = 4'b1000;
        tick(1);
        irq_w = '0;
        exp_q.push_back(8'h02);
        tick(4);
        chk("t6_nint", {7'd0, nint_w}, 8'h00);
        inta_begin();
        sb_chk("t6_wrap_vec", d_out_w);
        inta_end();
        irq_w = 4'b1000;
        tick(1);
        irq_w = '0;
        tick(4);
        inta_begin();
        rst_n = 1'b0;
        #1;
        exp_q.push_back(8'hFF);
        chk("t6_rst_nint_ack", {7'd0, nint_w}, 8'h01);
        chk("t6_rst_doe", {7'd0, d_oe_w}, 8'h01);
        sb_chk("t6_rst_vec", d_out_w);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        exp_q.push_back(8'hFF);
        sb_chk("t6_post_rst_vec", d_out_w);
        chk("t6_post_rst_nint", {7'd0, nint_w}, 8'h01);
        inta_end();
        io_read(8'h03, rd_a, rd_w);
        chk("t6_pending", rd_w, 8'h00);
        io_read(8'h04, rd_a, rd_w);
        chk("t6_mask", rd_w, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
